addsub_acc: RTL and testbench

ADDSUB_ACC -- requirements
Module: addsub_acc

---
 rtl/addsub_pkg.sv | 35 +++
 rtl/addsub_core.sv | 31 +++
 rtl/addsub_acc.sv | 95 +++++++++
 tb/tb_addsub_acc.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
//------------------------------------------------------------------------------
// addsub_pkg
//   Shared operation codes, result-flag bundle and helpers for addsub_acc.
//   Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ACC = 2'd2,
        OP_DEC = 2'd3
    } op_e;

    typedef struct packed {
        logic carry;
        logic ovf;
        logic zero;
    } flags_t;

    // Operations that read and write back the accumulator.
    function automatic logic is_acc_op(input op_e op);
        return (op == OP_ACC) || (op == OP_DEC);
    endfunction

    // Operations that subtract their second operand.
    function automatic logic is_sub_op(input op_e op);
        return (op == OP_SUB) || (op == OP_DEC);
    endfunction

endpackage

`default_nettype wire

// File: rtl/addsub_core.sv
//------------------------------------------------------------------------------
// addsub_core
//   Combinational WIDTH-bit adder/subtractor with carry/borrow and overflow.
//   Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module addsub_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;

    // Subtraction is a + ~b + 1; the raw carry-out is inverted to give a borrow.
    assign w_b   = sub ? ~b : b;
    assign w_sum = {1'b0, a} + {1'b0, w_b} + {{WIDTH{1'b0}}, sub};
    assign y     = w_sum[WIDTH-1:0];
    assign carry = w_sum[WIDTH] ^ sub;
    assign ovf   = (a[WIDTH-1] == w_b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);

endmodule

`default_nettype wire

// File: rtl/addsub_acc.sv
//------------------------------------------------------------------------------
// addsub_acc
//   Handshaked add/subtract unit with wrap-around accumulator and one-entry
//   registered output stage.
//   Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module addsub_acc
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  op_e              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             acc_clr_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] y_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] r_acc;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    flags_t           r_flags;

    logic             w_accept;
    logic             w_acc_op;
    logic [WIDTH-1:0] w_acc_base;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_opb;
    logic [WIDTH-1:0] w_y;
    logic             w_carry;
    logic             w_ovf;

    assign in_ready_o = !r_out_valid || out_ready_i;
    assign w_accept   = in_valid_i && in_ready_o;
    assign w_acc_op   = is_acc_op(op_i);

    // A same-cycle clear takes effect before the accumulating operation.
    assign w_acc_base = acc_clr_i ? '0 : r_acc;
    assign w_opa      = w_acc_op ? w_acc_base : a_i;
    assign w_opb      = w_acc_op ? a_i : b_i;

    addsub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a     (w_opa),
        .b     (w_opb),
        .sub   (is_sub_op(op_i)),
        .y     (w_y),
        .carry (w_carry),
        .ovf   (w_ovf)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_flags     <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_y         <= w_y;
                r_flags     <= '{carry: w_carry, ovf: w_ovf, zero: (w_y == '0)};
            end else if (out_ready_i) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept && w_acc_op) begin
                r_acc <= w_y;
            end else if (acc_clr_i) begin
                r_acc <= '0;
            end
        end
    end

    assign out_valid_o = r_out_valid;
    assign y_o         = r_y;
    assign carry_o     = r_flags.carry;
    assign ovf_o       = r_flags.ovf;
    assign zero_o      = r_flags.zero;

endmodule

`default_nettype wire

// File: tb/tb_addsub_acc.sv
//------------------------------------------------------------------------------
// tb_addsub_acc
//   Scoreboard bench for addsub_acc (WIDTH=4): directed vectors plus random ops.
//   Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_addsub_acc;
    import addsub_pkg::*;

    localparam int W = 4;
    localparam int M = 1 << W;

    typedef struct {
        logic [W-1:0] y;
        logic [2:0]   f;   // {carry, ovf, zero}
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         in_valid_i;
    logic         in_ready_o;
    op_e          op_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         acc_clr_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] y_o;
    logic         carry_o;
    logic         ovf_o;
    logic         zero_o;

    always #5 clk = ~clk;

    addsub_acc #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_i        (op_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .acc_clr_i   (acc_clr_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .y_o         (y_o),
        .carry_o     (carry_o),
        .ovf_o       (ovf_o),
        .zero_o      (zero_o)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   armed   = 1'b0;
    bit   rnd     = 1'b0;
    int   m_acc   = 0;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= M / 2) ? x - M : x;
    endfunction

    // Reference arithmetic computed on plain integers.
    function automatic exp_t model(input op_e op, input int a, input int b, input int acc);
        int   x, z, r, s;
        bit   c, v;
        exp_t e;
        if (op == OP_ACC || op == OP_DEC) begin x = acc; z = a; end
        else begin x = a; z = b; end
        if (op == OP_ADD || op == OP_ACC) begin
            r = x + z;      c = (r >= M);  s = sgn(x) + sgn(z);
        end else begin
            r = x - z + M;  c = (x < z);   s = sgn(x) - sgn(z);
        end
        r   = r % M;
        v   = (s > M / 2 - 1) || (s < -(M / 2));
        e.y = r[W-1:0];
        e.f = {c, v, (r == 0)};
        return e;
    endfunction

    // Observer: records each accepted transaction and tracks the accumulator.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (armed) begin
                if (rst_i) begin
                    sb.delete();
                    m_acc = 0;
                end else if (in_valid_i && in_ready_o) begin
                    e = model(op_i, int'(a_i), int'(b_i), acc_clr_i ? 0 : m_acc);
                    sb.push_back(e);
                    if (op_i == OP_ACC || op_i == OP_DEC) m_acc = int'(e.y);
                    else if (acc_clr_i) m_acc = 0;
                end else if (acc_clr_i) begin
                    m_acc = 0;
                end
            end
        end
    end

    // Monitor: handshake sanity and scoreboard pop on each delivered result.
    always @(negedge clk) begin
        exp_t e;
        if (armed) begin
            chk("in_ready", in_ready_o, !out_valid_o || out_ready_i);
            chk("out_valid", out_valid_o, sb.size() != 0);
            if (out_valid_o && out_ready_i && !rst_i && sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_y", y_o, e.y);
                chk("sb_flags", {carry_o, ovf_o, zero_o}, e.f);
            end
        end
    end

    task automatic send(input op_e op, input int a, input int b, input bit clr);
        int   n;
        logic [31:0] av, bv;
        av = a; bv = b;
        in_valid_i = 1'b1;
        op_i       = op;
        a_i        = av[W-1:0];
        b_i        = bv[W-1:0];
        acc_clr_i  = clr;
        if (rnd) out_ready_i = ($urandom % 4) != 0;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready_o) break;
            n++;
            if (n > 100) begin
                chk("accept_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
            if (rnd) out_ready_i = ($urandom % 4) != 0;
        end
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        acc_clr_i  = 1'b0;
    endtask

    task automatic send_chk(input op_e op, input int a, input int b, input bit clr,
                            input int ey, input logic [2:0] ef);
        send(op, a, b, clr);
        @(negedge clk);
        chk("dir_y", y_o, ey);
        chk("dir_flags", {carry_o, ovf_o, zero_o}, ef);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_i = 1'b1; in_valid_i = 1'b0; op_i = OP_ADD; a_i = '0; b_i = '0;
        acc_clr_i = 1'b0; out_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        armed = 1'b1;
        @(negedge clk);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_ready", in_ready_o, 1);
        chk("rst_y", y_o, 0);
        chk("rst_flags", {carry_o, ovf_o, zero_o}, 3'b000);
        @(posedge clk); #1;

        // Back-to-back ADD/SUB.
        send(OP_ADD, 4, 2, 0);
        send(OP_SUB, 4, 2, 0);
        @(negedge clk);
        chk("b2b_y", y_o, 2);
        @(posedge clk); #1;

        send_chk(OP_ADD, 7, 1, 0, 8, 3'b010);
        send_chk(OP_SUB, 2, 3, 0, 15, 3'b100);
        send_chk(OP_ADD, 15, 1, 0, 0, 3'b101);

        send_chk(OP_ACC, 7, 9, 0, 7, 3'b000);
        send_chk(OP_ACC, 3, 0, 0, 10, 3'b010);
        send_chk(OP_DEC, 4, 5, 0, 6, 3'b010);
        send_chk(OP_ACC, 10, 0, 0, 0, 3'b101);

        // Back-pressure: result held, next op waits.
        out_ready_i = 1'b0;
        send(OP_ADD, 7, 3, 0);
        in_valid_i = 1'b1; op_i = OP_ADD; a_i = 4'd1; b_i = 4'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_y", y_o, 10);
            chk("hold_ready", in_ready_o, 0);
        end
        @(posedge clk); #1;
        out_ready_i = 1'b1;
        @(negedge clk);
        chk("release_ready", in_ready_o, 1);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("release_y", y_o, 2);
        @(posedge clk); #1;

        // Clear together with an accumulate.
        send(OP_ADD, 0, 0, 1);
        send_chk(OP_ACC, 5, 0, 0, 5, 3'b000);
        send_chk(OP_ACC, 2, 0, 1, 2, 3'b000);

        // Reset while a result is held and a new op is offered.
        out_ready_i = 1'b0;
        send(OP_ADD, 1, 1, 0);
        rst_i = 1'b1; out_ready_i = 1'b1;
        in_valid_i = 1'b1; op_i = OP_ACC; a_i = 4'd3;
        @(posedge clk); #1;
        rst_i = 1'b0; in_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", out_valid_o, 0);
        @(posedge clk); #1;
        send_chk(OP_ACC, 4, 0, 0, 4, 3'b000);

        // Random traffic with random back-pressure.
        rnd = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom % 8 == 0) begin
                out_ready_i = ($urandom % 4) != 0;
                acc_clr_i   = ($urandom % 2) != 0;
                @(posedge clk); #1;
                acc_clr_i   = 1'b0;
            end
            send(op_e'($urandom_range(0, 3)), int'($urandom_range(0, M - 1)),
                 int'($urandom_range(0, M - 1)), ($urandom % 10) == 0);
        end
        rnd = 1'b0;
        out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
